// File: rtl/seq_match_monitor.sv
// Monitor for the 1011 sequence detector. It counts detections, measures the spacing
// between them, and raises a sticky alarm when a burst of detections falls inside a window.
module seq_match_monitor #(
   parameter int CNT_W = 16,
   parameter int WIN_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic             match,
   input  logic [WIN_W-1:0] win_len,
   input  logic [WIN_W-1:0] thresh,
   output logic [CNT_W-1:0] total_cnt,
   output logic [WIN_W-1:0] win_cnt,
   output logic [CNT_W-1:0] last_gap,
   output logic             gap_valid,
   output logic             alarm,
   output logic             alarm_pulse,
   output logic [1:0]       state
);
   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ARMED = 2'b01,
      TRACK = 2'b10,
      ALARM = 2'b11
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [WIN_W-1:0] WIN_ZERO = {WIN_W{1'b0}};
   localparam logic [WIN_W-1:0] WIN_ONE  = {{(WIN_W-1){1'b0}}, 1'b1};
   localparam logic [WIN_W-1:0] WIN_MAX  = {WIN_W{1'b1}};

   function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : (v + CNT_ONE);
   endfunction

   function automatic logic [WIN_W-1:0] sat_inc_win(input logic [WIN_W-1:0] v);
      return (v == WIN_MAX) ? v : (v + WIN_ONE);
   endfunction

   state_t           state_r, state_s;
   logic [CNT_W-1:0] total_r, total_s, gap_r, gap_s, gap_tmr_r, gap_tmr_s;
   logic [WIN_W-1:0] win_r, win_s, win_tmr_r, win_tmr_s, thr_r, thr_s;
   logic             gv_r, gv_s, seen_r, seen_s, alarm_r, alarm_s, pulse_r, pulse_s;
   logic             acc_s, open_s, raise_s;
   logic [WIN_W-1:0] open_tmr_s, win_inc_s;

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state and next-value logic for every register
   always_comb begin
      state_s    = state_r;
      total_s    = total_r;
      gap_s      = gap_r;
      gap_tmr_s  = gap_tmr_r;
      win_s      = win_r;
      win_tmr_s  = win_tmr_r;
      thr_s      = thr_r;
      gv_s       = gv_r;
      seen_s     = seen_r;
      alarm_s    = alarm_r;
      pulse_s    = 1'b0;
      acc_s      = 1'b0;
      open_s     = 1'b0;
      raise_s    = 1'b0;
      open_tmr_s = (win_len == WIN_ZERO) ? WIN_ZERO : (win_len - WIN_ONE);
      win_inc_s  = sat_inc_win(win_r);
      if (clr) begin
         state_s   = en ? ARMED : IDLE;
         total_s   = CNT_ZERO;
         gap_s     = CNT_ZERO;
         gap_tmr_s = CNT_ZERO;
         win_s     = WIN_ZERO;
         win_tmr_s = WIN_ZERO;
         gv_s      = 1'b0;
         seen_s    = 1'b0;
         alarm_s   = 1'b0;
      end else if (!en) begin
         state_s   = IDLE;
         win_s     = WIN_ZERO;
         win_tmr_s = WIN_ZERO;
         gap_tmr_s = sat_inc_cnt(gap_tmr_r);
      end else begin
         acc_s = match && (state_r != IDLE);
         if (acc_s) begin
            total_s   = sat_inc_cnt(total_r);
            gap_tmr_s = CNT_ONE;
            seen_s    = 1'b1;
            if (seen_r) begin
               gap_s = gap_tmr_r;
               gv_s  = 1'b1;
            end else begin
               gap_s = gap_r;
            end
         end else begin
            gap_tmr_s = sat_inc_cnt(gap_tmr_r);
         end
         case (state_r)
            IDLE:  state_s = ARMED;
            ARMED: begin
               if (match) begin
                  open_s = 1'b1;
               end else begin
                  state_s = ARMED;
               end
            end
            TRACK: begin
               if (win_tmr_r == WIN_ZERO) begin
                  if (match) begin
                     open_s = 1'b1;
                  end else begin
                     state_s = ARMED;
                     win_s   = WIN_ZERO;
                  end
               end else begin
                  win_tmr_s = win_tmr_r - WIN_ONE;
                  if (match) begin
                     win_s   = win_inc_s;
                     raise_s = (thr_r != WIN_ZERO) && (win_inc_s >= thr_r);
                  end else begin
                     win_s = win_r;
                  end
               end
            end
            ALARM:   state_s = ALARM;
            default: state_s = IDLE;
         endcase
         // A fresh window samples win_len/thresh; threshold 1 trips on the opening match
         if (open_s) begin
            state_s   = TRACK;
            win_s     = WIN_ONE;
            win_tmr_s = open_tmr_s;
            thr_s     = thresh;
            raise_s   = (thresh == WIN_ONE);
         end else begin
            thr_s = thr_r;
         end
         if (raise_s) begin
            state_s = ALARM;
            alarm_s = 1'b1;
            pulse_s = 1'b1;
         end else begin
            pulse_s = 1'b0;
         end
      end
   end

   // Counter, timer and flag registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         total_r   <= CNT_ZERO;
         gap_r     <= CNT_ZERO;
         gap_tmr_r <= CNT_ZERO;
         win_r     <= WIN_ZERO;
         win_tmr_r <= WIN_ZERO;
         thr_r     <= WIN_ZERO;
         gv_r      <= 1'b0;
         seen_r    <= 1'b0;
         alarm_r   <= 1'b0;
         pulse_r   <= 1'b0;
      end else begin
         total_r   <= total_s;
         gap_r     <= gap_s;
         gap_tmr_r <= gap_tmr_s;
         win_r     <= win_s;
         win_tmr_r <= win_tmr_s;
         thr_r     <= thr_s;
         gv_r      <= gv_s;
         seen_r    <= seen_s;
         alarm_r   <= alarm_s;
         pulse_r   <= pulse_s;
      end
   end

   assign total_cnt   = total_r;
   assign win_cnt     = win_r;
   assign last_gap    = gap_r;
   assign gap_valid   = gv_r;
   assign alarm       = alarm_r;
   assign alarm_pulse = pulse_r;
   assign state       = state_r;
endmodule

// File: tb/tb_seq_match_monitor.sv
// Scoreboard bench for seq_match_monitor: a default-width instance plus a CNT_W=4
// instance share the stimulus so that counter saturation is reachable quickly.
module tb_seq_match_monitor;
   logic        clk = 1'b0;
   logic        rst, en, clr, match;
   logic [7:0]  win_len, thresh;
   logic [15:0] total_a, gap_a;
   logic [7:0]  win_a, win_b;
   logic [3:0]  total_b, gap_b;
   logic        gv_a, al_a, pl_a, gv_b, al_b, pl_b;
   logic [1:0]  st_a, st_b;

   typedef struct packed {
      logic [15:0] tot;
      logic [7:0]  win;
      logic [15:0] gap;
      logic        gv;
      logic        al;
      logic        pl;
      logic [1:0]  st;
   } obs_t;
   typedef struct {
      string tag;
      obs_t  v;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   seq_match_monitor dut_a (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .match(match),
      .win_len(win_len), .thresh(thresh),
      .total_cnt(total_a), .win_cnt(win_a), .last_gap(gap_a), .gap_valid(gv_a),
      .alarm(al_a), .alarm_pulse(pl_a), .state(st_a)
   );

   seq_match_monitor #(.CNT_W(4), .WIN_W(8)) dut_b (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .match(match),
      .win_len(win_len), .thresh(thresh),
      .total_cnt(total_b), .win_cnt(win_b), .last_gap(gap_b), .gap_valid(gv_b),
      .alarm(al_b), .alarm_pulse(pl_b), .state(st_b)
   );

   function automatic obs_t mk(input logic [15:0] tot, input logic [7:0] win,
                               input logic [15:0] gap, input logic gv, input logic al,
                               input logic pl, input logic [1:0] st);
      obs_t o;
      o.tot = tot; o.win = win; o.gap = gap; o.gv = gv; o.al = al; o.pl = pl; o.st = st;
      return o;
   endfunction

   function automatic obs_t obs_a();
      return mk(total_a, win_a, gap_a, gv_a, al_a, pl_a, st_a);
   endfunction

   function automatic obs_t obs_b();
      return mk({12'd0, total_b}, win_b, {12'd0, gap_b}, gv_b, al_b, pl_b, st_b);
   endfunction

   function automatic string fmt(input obs_t v);
      return $sformatf("tot=%0d win=%0d gap=%0d gv=%b al=%b pl=%b st=%b",
                       v.tot, v.win, v.gap, v.gv, v.al, v.pl, v.st);
   endfunction

   task automatic push(input string tag, input obs_t v);
      exp_t e;
      e.tag = tag;
      e.v   = v;
      sb.push_back(e);
   endtask

   task automatic cyc(input logic m);
      match = m;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      exp_t e; obs_t got;
      rst = 1'b1; en = 1'b1; clr = 1'b0; match = 1'b0; win_len = 8'd20; thresh = 8'd3;
      #2 rst = 1'b0;
      for (int i = 0; i < 4; i++) cyc(i[0]);
      push("rst_hold", mk(16'd0, 8'd0, 16'd0, 1'b0, 1'b0, 1'b0, 2'b00));
      e = sb.pop_front(); got = obs_a(); n_vec++;
      if (got !== e.v) begin n_bad++; $display("FAIL %s: got %s want %s", e.tag, fmt(got), fmt(e.v)); end
      rst = 1'b1; match = 1'b0; #1;
      push("rst_release", mk(16'd0, 8'd0, 16'd0, 1'b0, 1'b0, 1'b0, 2'b00));
      e = sb.pop_front(); got = obs_a(); n_vec++;
      if (got !== e.v) begin n_bad++; $display("FAIL %s: got %s want %s", e.tag, fmt(got), fmt(e.v)); end
      push("rst_armed", mk(16'd0, 8'd0, 16'd0, 1'b0, 1'b0, 1'b0, 2'b01));
      cyc(1'b1);
      e = sb.pop_front(); got = obs_a(); n_vec++;
      if (got !== e.v) begin n_bad++; $display("FAIL %s: got %s want %s", e.tag, fmt(got), fmt(e.v)); end
   endtask

   task automatic test_overlap();
      exp_t e; obs_t got;
      cyc(1'b0); cyc(1'b0);
      push("ovl_m1", mk(16'd1, 8'd1, 16'd0, 1'b0, 1'b0, 1'b0, 2'b10));
      cyc(1'b1);
      e = sb.pop_front(); got = obs_a(); n_vec++;
      if (got !== e.v) begin n_bad++; $display("FAIL %s: got %s want %s", e.tag, fmt(got), fmt(e.v)); end
      cyc(1'b0); cyc(1'b0);
      push("ovl_m2", mk(16'd2, 8'd2, 16'd3, 1'b1, 1'b0, 1'b0, 2'b10));
      cyc(1'b1);
      e = sb.pop_front(); got = obs_a(); n_vec++;
      if (got !== e.v) begin n_bad++; $display("FAIL %s: got %s want %s", e.tag, fmt(got), fmt(e.v)); end
      cyc(1'b0); cyc(1'b0);
      push("ovl_m3", mk(16'd3, 8'd3, 16'd3, 1'b1, 1'b1, 1'b1, 2'b11));
      cyc(1'b1);
      e = sb.pop_front(); got = obs_a(); n_vec++;
      if (got !== e.v) begin n_bad++; $display("FAIL %s: got %s want %s", e.tag, fmt(got), fmt(e.v)); end
      push("ovl_hold", mk(16'd3, 8'd3, 16'd3, 1'b1, 1'b1, 1'b0, 2'b11));
      cyc(1'b0);
      e = sb.pop_front(); got = obs_a(); n_vec++;
      if (got !== e.v) begin n_bad++; $display("FAIL %s: got %s want %s", e.tag, fmt(got), fmt(e.v)); end
      push("alarm_count", mk(16'd4, 8'd3, 16'd2, 1'b1, 1'b1, 1'b0, 2'b11));
      cyc(1'b1);
      e = sb.pop_front(); got = obs_a(); n_vec++;
      if (got !== e.v) begin n_bad++; $display("FAIL %s: got %s want %s", e.tag, fmt(got), fmt(e.v)); end
   endtask

   task automatic test_clr_en();
      exp_t e; obs_t got;
      clr = 1'b1;
      push("clr", mk(16'd0, 8'd0, 16'd0, 1'b0, 1'b0, 1'b0, 2'b01));
      cyc(1'b1);
      clr = 1'b0;
      e = sb.pop_front(); got = obs_a(); n_vec++;
      if (got !== e.v) begin n_bad++; $display("FAIL %s: got %s want %s", e.tag, fmt(got), fmt(e.v)); end
      en = 1'b0;
      push("en_drop", mk(16'd0, 8'd0, 16'd0, 1'b0, 1'b0, 1'b0, 2'b00));
      cyc(1'b0);
      e = sb.pop_front(); got = obs_a(); n_vec++;
      if (got !== e.v) begin n_bad++; $display("FAIL %s: got %s want %s", e.tag, fmt(got), fmt(e.v)); end
      push("en0_match", mk(16'd0, 8'd0, 16'd0, 1'b0, 1'b0, 1'b0, 2'b00));
      cyc(1'b1);
      e = sb.pop_front(); got = obs_a(); n_vec++;
      if (got !== e.v) begin n_bad++; $display("FAIL %s: got %s want %s", e.tag, fmt(got), fmt(e.v)); end
      en = 1'b1;
      push("idle_trans", mk(16'd0, 8'd0, 16'd0, 1'b0, 1'b0, 1'b0, 2'b01));
      cyc(1'b1);
      e = sb.pop_front(); got = obs_a(); n_vec++;
      if (got !== e.v) begin n_bad++; $display("FAIL %s: got %s want %s", e.tag, fmt(got), fmt(e.v)); end
   endtask

   task automatic test_window_expiry();
      exp_t e; obs_t got;
      win_len = 8'd4; thresh = 8'd2;
      push("win_open", mk(16'd1, 8'd1, 16'd0, 1'b0, 1'b0, 1'b0, 2'b10));
      cyc(1'b1);
      e = sb.pop_front(); got = obs_a(); n_vec++;
      if (got !== e.v) begin n_bad++; $display("FAIL %s: got %s want %s", e.tag, fmt(got), fmt(e.v)); end
      cyc(1'b0); cyc(1'b0); cyc(1'b0);
      push("win_close", mk(16'd1, 8'd0, 16'd0, 1'b0, 1'b0, 1'b0, 2'b01));
      cyc(1'b0);
      e = sb.pop_front(); got = obs_a(); n_vec++;
      if (got !== e.v) begin n_bad++; $display("FAIL %s: got %s want %s", e.tag, fmt(got), fmt(e.v)); end
      push("win_reopen", mk(16'd2, 8'd1, 16'd5, 1'b1, 1'b0, 1'b0, 2'b10));
      cyc(1'b1);
      e = sb.pop_front(); got = obs_a(); n_vec++;
      if (got !== e.v) begin n_bad++; $display("FAIL %s: got %s want %s", e.tag, fmt(got), fmt(e.v)); end
      en = 1'b0;
      push("en0_hold", mk(16'd2, 8'd0, 16'd5, 1'b1, 1'b0, 1'b0, 2'b00));
      cyc(1'b0);
      e = sb.pop_front(); got = obs_a(); n_vec++;
      if (got !== e.v) begin n_bad++; $display("FAIL %s: got %s want %s", e.tag, fmt(got), fmt(e.v)); end
   endtask

   task automatic test_close_open();
      exp_t e; obs_t got;
      en = 1'b1; clr = 1'b1;
      push("clr_idle", mk(16'd0, 8'd0, 16'd0, 1'b0, 1'b0, 1'b0, 2'b01));
      cyc(1'b0);
      clr = 1'b0;
      e = sb.pop_front(); got = obs_a(); n_vec++;
      if (got !== e.v) begin n_bad++; $display("FAIL %s: got %s want %s", e.tag, fmt(got), fmt(e.v)); end
      win_len = 8'd3; thresh = 8'd5;
      push("co_open", mk(16'd1, 8'd1, 16'd0, 1'b0, 1'b0, 1'b0, 2'b10));
      cyc(1'b1);
      e = sb.pop_front(); got = obs_a(); n_vec++;
      if (got !== e.v) begin n_bad++; $display("FAIL %s: got %s want %s", e.tag, fmt(got), fmt(e.v)); end
      cyc(1'b0); cyc(1'b0);
      push("close_open", mk(16'd2, 8'd1, 16'd3, 1'b1, 1'b0, 1'b0, 2'b10));
      cyc(1'b1);
      e = sb.pop_front(); got = obs_a(); n_vec++;
      if (got !== e.v) begin n_bad++; $display("FAIL %s: got %s want %s", e.tag, fmt(got), fmt(e.v)); end
      cyc(1'b0);
      push("reload_track", mk(16'd2, 8'd1, 16'd3, 1'b1, 1'b0, 1'b0, 2'b10));
      cyc(1'b0);
      e = sb.pop_front(); got = obs_a(); n_vec++;
      if (got !== e.v) begin n_bad++; $display("FAIL %s: got %s want %s", e.tag, fmt(got), fmt(e.v)); end
      push("second_close", mk(16'd2, 8'd0, 16'd3, 1'b1, 1'b0, 1'b0, 2'b01));
      cyc(1'b0);
      e = sb.pop_front(); got = obs_a(); n_vec++;
      if (got !== e.v) begin n_bad++; $display("FAIL %s: got %s want %s", e.tag, fmt(got), fmt(e.v)); end
   endtask

   task automatic test_saturation();
      exp_t e; obs_t got;
      clr = 1'b1;
      push("clr_sat", mk(16'd0, 8'd0, 16'd0, 1'b0, 1'b0, 1'b0, 2'b01));
      cyc(1'b0);
      clr = 1'b0;
      e = sb.pop_front(); got = obs_b(); n_vec++;
      if (got !== e.v) begin n_bad++; $display("FAIL %s: got %s want %s", e.tag, fmt(got), fmt(e.v)); end
      win_len = 8'd0; thresh = 8'd0;
      push("sat_cnt_a", mk(16'd20, 8'd1, 16'd3, 1'b1, 1'b0, 1'b0, 2'b10));
      push("sat_cnt_b", mk(16'd15, 8'd1, 16'd3, 1'b1, 1'b0, 1'b0, 2'b10));
      for (int i = 0; i < 20; i++) begin
         if (i != 0) begin
            cyc(1'b0); cyc(1'b0);
         end
         cyc(1'b1);
      end
      e = sb.pop_front(); got = obs_a(); n_vec++;
      if (got !== e.v) begin n_bad++; $display("FAIL %s: got %s want %s", e.tag, fmt(got), fmt(e.v)); end
      e = sb.pop_front(); got = obs_b(); n_vec++;
      if (got !== e.v) begin n_bad++; $display("FAIL %s: got %s want %s", e.tag, fmt(got), fmt(e.v)); end
      push("sat_gap_a", mk(16'd21, 8'd1, 16'd21, 1'b1, 1'b0, 1'b0, 2'b10));
      push("sat_gap_b", mk(16'd15, 8'd1, 16'd15, 1'b1, 1'b0, 1'b0, 2'b10));
      for (int i = 0; i < 20; i++) cyc(1'b0);
      cyc(1'b1);
      e = sb.pop_front(); got = obs_a(); n_vec++;
      if (got !== e.v) begin n_bad++; $display("FAIL %s: got %s want %s", e.tag, fmt(got), fmt(e.v)); end
      e = sb.pop_front(); got = obs_b(); n_vec++;
      if (got !== e.v) begin n_bad++; $display("FAIL %s: got %s want %s", e.tag, fmt(got), fmt(e.v)); end
   endtask

   task automatic test_back_to_back();
      exp_t e; obs_t got;
      clr = 1'b1;
      push("clr_b2b", mk(16'd0, 8'd0, 16'd0, 1'b0, 1'b0, 1'b0, 2'b01));
      cyc(1'b0);
      clr = 1'b0;
      e = sb.pop_front(); got = obs_a(); n_vec++;
      if (got !== e.v) begin n_bad++; $display("FAIL %s: got %s want %s", e.tag, fmt(got), fmt(e.v)); end
      win_len = 8'd5; thresh = 8'd1;
      push("thresh1", mk(16'd1, 8'd1, 16'd0, 1'b0, 1'b1, 1'b1, 2'b11));
      cyc(1'b1);
      e = sb.pop_front(); got = obs_a(); n_vec++;
      if (got !== e.v) begin n_bad++; $display("FAIL %s: got %s want %s", e.tag, fmt(got), fmt(e.v)); end
      push("b2b", mk(16'd2, 8'd1, 16'd1, 1'b1, 1'b1, 1'b0, 2'b11));
      cyc(1'b1);
      e = sb.pop_front(); got = obs_a(); n_vec++;
      if (got !== e.v) begin n_bad++; $display("FAIL %s: got %s want %s", e.tag, fmt(got), fmt(e.v)); end
   endtask

   task automatic test_reset_mid();
      exp_t e; obs_t got;
      push("rst_async", mk(16'd0, 8'd0, 16'd0, 1'b0, 1'b0, 1'b0, 2'b00));
      rst = 1'b0;
      #2;
      e = sb.pop_front(); got = obs_a(); n_vec++;
      if (got !== e.v) begin n_bad++; $display("FAIL %s: got %s want %s", e.tag, fmt(got), fmt(e.v)); end
      push("rst_held", mk(16'd0, 8'd0, 16'd0, 1'b0, 1'b0, 1'b0, 2'b00));
      cyc(1'b1);
      e = sb.pop_front(); got = obs_a(); n_vec++;
      if (got !== e.v) begin n_bad++; $display("FAIL %s: got %s want %s", e.tag, fmt(got), fmt(e.v)); end
      rst = 1'b1;
   endtask

   initial begin
      test_reset();
      test_overlap();
      test_clr_en();
      test_window_expiry();
      test_close_open();
      test_saturation();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
